// File: rtl/or1200_wb_biu_arb.sv
// -----------------------------------------------------------------------------
// or1200_wb_biu_arb
//
// Shares one external Wishbone master port between the OR1200 instruction bus
// (requester 0, iwb) and data bus (requester 1, dwb). A grant is held for the
// whole bus cycle (cyc high), so bursts are never split. A response watchdog
// terminates a stalled cycle with an error to the granted requester.
//
// Parameters
//   PRIORITY  0 = round-robin on contention, 1 = fixed priority (dwb wins)
//   TIMEOUT   stall cycles before the watchdog fires; 0 disables it
//   CNT_W     watchdog counter width, must be able to hold TIMEOUT
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_cyc/stb/we_i    per-requester control, bit0 = iwb, bit1 = dwb
//   req_sel_i           byte selects, [3:0] iwb, [7:4] dwb
//   req_adr/dat_i       address / write data, [31:0] iwb, [63:32] dwb
//   req_dat_o           read data, broadcast from wb_dat_i
//   req_ack/err/rty_o   responses, routed to the granted requester only
//   wb_*_o / wb_*_i     shared Wishbone master port
//   gnt_o               current grant: 01 = iwb, 10 = dwb, 00 = none
//   timeout_o           one-cycle pulse while the watchdog error is issued
// -----------------------------------------------------------------------------
module or1200_wb_biu_arb #(
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 256,
    parameter int CNT_W    = 9
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [1:0]  req_cyc_i,
    input  logic [1:0]  req_stb_i,
    input  logic [1:0]  req_we_i,
    input  logic [7:0]  req_sel_i,
    input  logic [63:0] req_adr_i,
    input  logic [63:0] req_dat_i,
    output logic [31:0] req_dat_o,
    output logic [1:0]  req_ack_o,
    output logic [1:0]  req_err_o,
    output logic [1:0]  req_rty_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,

    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TERR = 2'd2
    } state_e;

    localparam bit             WDOG_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WDOG_EN ? TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_dwb_q, last_dwb_d;   // 1 = dwb held the last grant
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       req;
    logic [1:0]       gnt_pick;
    logic             sel_dwb;
    logic             busy;
    logic             terr;
    logic             resp_any;

    // Granted requester's signals, selected by the registered grant.
    logic             g_cyc, g_stb, g_we;
    logic [3:0]       g_sel;
    logic [31:0]      g_adr, g_dat;

    assign req      = req_cyc_i & req_stb_i;
    assign sel_dwb  = gnt_q[1];
    assign busy     = (state_q == BUSY);
    assign terr     = (state_q == TERR);
    assign resp_any = wb_ack_i | wb_err_i | wb_rty_i;

    assign g_cyc = sel_dwb ? req_cyc_i[1]      : req_cyc_i[0];
    assign g_stb = sel_dwb ? req_stb_i[1]      : req_stb_i[0];
    assign g_we  = sel_dwb ? req_we_i[1]       : req_we_i[0];
    assign g_sel = sel_dwb ? req_sel_i[7:4]    : req_sel_i[3:0];
    assign g_adr = sel_dwb ? req_adr_i[63:32]  : req_adr_i[31:0];
    assign g_dat = sel_dwb ? req_dat_i[63:32]  : req_dat_i[31:0];

    // Master port: a passthrough of the granted requester in BUSY, all zero
    // otherwise. Passing cyc straight through lets wb_cyc_o fall in the same
    // cycle the requester drops it.
    assign wb_cyc_o = busy & g_cyc;
    assign wb_stb_o = busy & g_stb;
    assign wb_we_o  = busy & g_we;
    assign wb_sel_o = busy ? g_sel : 4'h0;
    assign wb_adr_o = busy ? g_adr : 32'h0;
    assign wb_dat_o = busy ? g_dat : 32'h0;

    // Responses reach a requester only while its cycle is live; anything the
    // slave returns in IDLE or TERR (late or post-reset) is dropped here.
    assign req_ack_o = busy ? (gnt_q & {2{wb_ack_i}}) : 2'b00;
    assign req_rty_o = busy ? (gnt_q & {2{wb_rty_i}}) : 2'b00;
    assign req_err_o = busy ? (gnt_q & {2{wb_err_i}})
                     : (terr ? gnt_q : 2'b00);

    assign req_dat_o = wb_dat_i;
    assign gnt_o     = gnt_q;
    assign timeout_o = timeout_q;

    // Arbitration decision for a request seen in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt_pick = 2'b00;
        unique case (req)
            2'b01:   gnt_pick = 2'b01;
            2'b10:   gnt_pick = 2'b10;
            2'b11: begin
                // Fixed priority favours dwb; round-robin favours whoever did
                // not win last time (last-grant resets to iwb, so dwb first).
                if (PRIORITY != 0 || !last_dwb_q) gnt_pick = 2'b10;
                else                              gnt_pick = 2'b01;
            end
            default: gnt_pick = 2'b00;
        endcase
    end

    // Next-state logic for the FSM, grant, round-robin pointer and watchdog.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_dwb_d = last_dwb_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    state_d    = BUSY;
                    gnt_d      = gnt_pick;
                    last_dwb_d = gnt_pick[1];
                end
            end

            BUSY: begin
                if (!g_cyc) begin
                    // End of tenure: always pass through IDLE before re-arbitrating.
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = '0;
                end else if (resp_any) begin
                    // A response on the threshold cycle still wins over the watchdog.
                    cnt_d = '0;
                end else if (wb_stb_o && WDOG_EN) begin
                    if (cnt_q == TO_LAST) begin
                        state_d   = TERR;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // stb gaps without a response hold the count.
            end

            TERR: begin
                // Grant is kept through TERR so the error reaches the right
                // requester, then released.
                state_d = IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            last_dwb_q <= 1'b0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_dwb_q <= last_dwb_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_or1200_wb_biu_arb.sv
// -----------------------------------------------------------------------------
// tb_or1200_wb_biu_arb
//
// Directed bench for or1200_wb_biu_arb. Three instances share one stimulus:
//   u[0]: PRIORITY=0, TIMEOUT=16   u[1]: PRIORITY=1, TIMEOUT=16
//   u[2]: PRIORITY=0, TIMEOUT=0 (watchdog disabled)
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// following falling edge.
// -----------------------------------------------------------------------------
module tb_or1200_wb_biu_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_cyc, req_stb, req_we;
    logic [7:0]  req_sel;
    logic [63:0] req_adr, req_dat;
    logic [31:0] wb_dat_in;
    logic        wb_ack, wb_err, wb_rty;

    logic [31:0] o_req_dat [3];
    logic [1:0]  o_ack     [3];
    logic [1:0]  o_err     [3];
    logic [1:0]  o_rty     [3];
    logic        o_cyc     [3];
    logic        o_stb     [3];
    logic        o_we      [3];
    logic [3:0]  o_sel     [3];
    logic [31:0] o_adr     [3];
    logic [31:0] o_dat     [3];
    logic [1:0]  o_gnt     [3];
    logic        o_to      [3];

    int n_vec = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        or1200_wb_biu_arb #(
            .PRIORITY ((g == 1) ? 1 : 0),
            .TIMEOUT  ((g == 2) ? 0 : 16),
            .CNT_W    (9)
        ) u_dut (
            .clk_i     (clk),
            .rst_i     (rst),
            .req_cyc_i (req_cyc),
            .req_stb_i (req_stb),
            .req_we_i  (req_we),
            .req_sel_i (req_sel),
            .req_adr_i (req_adr),
            .req_dat_i (req_dat),
            .req_dat_o (o_req_dat[g]),
            .req_ack_o (o_ack[g]),
            .req_err_o (o_err[g]),
            .req_rty_o (o_rty[g]),
            .wb_cyc_o  (o_cyc[g]),
            .wb_stb_o  (o_stb[g]),
            .wb_we_o   (o_we[g]),
            .wb_sel_o  (o_sel[g]),
            .wb_adr_o  (o_adr[g]),
            .wb_dat_o  (o_dat[g]),
            .wb_dat_i  (wb_dat_in),
            .wb_ack_i  (wb_ack),
            .wb_err_i  (wb_err),
            .wb_rty_i  (wb_rty),
            .gnt_o     (o_gnt[g]),
            .timeout_o (o_to[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic cyc, input logic stb);
        req_cyc[n] = cyc;
        req_stb[n] = stb;
    endtask

    task automatic clear_inputs();
        req_cyc   = 2'b00;
        req_stb   = 2'b00;
        req_we    = 2'b00;
        req_sel   = 8'hFF;
        req_adr   = 64'h0;
        req_dat   = 64'h0;
        wb_dat_in = 32'h0;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        wb_rty    = 1'b0;
    endtask

    // Leaves the bench just after the reset edge, in the first IDLE cycle.
    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] burst_stb;
        burst_stb = 5'b11011;   // beat order LSB first: gap on the 3rd slot

        clear_inputs();
        rst = 1'b1;
        req_adr = 64'h0000_1234_0000_5678;  // idle outputs must still be 0
        step();
        step();
        mid();
        check("rst_gnt",   64'(o_gnt[0]), 64'h0);
        check("rst_cyc",   64'(o_cyc[0]), 64'h0);
        check("rst_adr",   64'(o_adr[0]), 64'h0);
        check("rst_to",    64'(o_to[0]),  64'h0);
        check("rst_err",   64'(o_err[0]), 64'h0);
        rst = 1'b0;

        // ---- 1: iwb read alone --------------------------------------------
        do_reset();
        set_req(0, 1'b1, 1'b1);
        req_adr[31:0] = 32'h0000_0100;
        mid();
        check("t1_idle_gnt", 64'(o_gnt[0]), 64'h0);
        check("t1_idle_cyc", 64'(o_cyc[0]), 64'h0);
        step();
        mid();
        check("t1_gnt",  64'(o_gnt[0]), 64'h1);
        check("t1_adr",  64'(o_adr[0]), 64'h100);
        check("t1_cyc",  64'(o_cyc[0]), 64'h1);
        check("t1_ack0", 64'(o_ack[0]), 64'h0);
        step();
        mid();
        check("t1_ack1", 64'(o_ack[0]), 64'h0);
        step();
        wb_ack = 1'b1;
        wb_dat_in = 32'hDEAD_BEEF;
        mid();
        check("t1_ack",  64'(o_ack[0]),     64'h1);
        check("t1_rdat", 64'(o_req_dat[0]), 64'hDEAD_BEEF);
        step();
        wb_ack = 1'b0;
        set_req(0, 1'b0, 1'b0);
        mid();
        check("t1_ack_end", 64'(o_ack[0]), 64'h0);
        check("t1_cyc_end", 64'(o_cyc[0]), 64'h0);
        step();
        mid();
        check("t1_gnt_end", 64'(o_gnt[0]), 64'h0);

        // ---- 2: round-robin contention ------------------------------------
        do_reset();
        set_req(0, 1'b1, 1'b1);
        set_req(1, 1'b1, 1'b1);
        req_adr = 64'h0000_2000_0000_0300;
        step();
        mid();
        check("t2_gnt_rr_first", 64'(o_gnt[0]), 64'h2);
        check("t2_gnt_fp_first", 64'(o_gnt[1]), 64'h2);
        check("t2_adr_dwb",      64'(o_adr[0]), 64'h2000);
        step();
        wb_ack = 1'b1;
        mid();
        check("t2_ack_dwb", 64'(o_ack[0]), 64'h2);
        step();
        wb_ack = 1'b0;
        set_req(1, 1'b0, 1'b0);
        mid();
        check("t2_cyc_fall", 64'(o_cyc[0]), 64'h0);
        step();
        mid();
        check("t2_idle_gap", 64'(o_gnt[0]), 64'h0);
        step();
        mid();
        check("t2_gnt_iwb", 64'(o_gnt[0]), 64'h1);
        check("t2_adr_iwb", 64'(o_adr[0]), 64'h300);
        step();
        wb_ack = 1'b1;
        mid();
        check("t2_ack_iwb", 64'(o_ack[0]), 64'h1);
        step();
        wb_ack = 1'b0;
        set_req(0, 1'b0, 1'b0);
        step();
        set_req(0, 1'b1, 1'b1);
        set_req(1, 1'b1, 1'b1);
        step();
        mid();
        check("t2_gnt_rr_again", 64'(o_gnt[0]), 64'h2);
        step();
        wb_ack = 1'b1;
        step();
        wb_ack = 1'b0;
        set_req(1, 1'b0, 1'b0);
        step();
        set_req(1, 1'b1, 1'b1);
        step();
        mid();
        check("t2_gnt_rr_alt", 64'(o_gnt[0]), 64'h1);
        check("t2_gnt_fp_alt", 64'(o_gnt[1]), 64'h2);

        // ---- 3: fixed priority, both requesting continuously ---------------
        do_reset();
        set_req(0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++) begin
            case (k % 3)
                0: begin set_req(1, 1'b1, 1'b1); wb_ack = 1'b0; end
                1: begin set_req(1, 1'b1, 1'b1); wb_ack = 1'b1; end
                default: begin set_req(1, 1'b0, 1'b0); wb_ack = 1'b0; end
            endcase
            mid();
            check($sformatf("t3_gnt_%0d", k), 64'(o_gnt[1]),
                  (k % 3 == 0) ? 64'h0 : 64'h2);
            if (k % 3 == 1)
                check($sformatf("t3_ack_%0d", k), 64'(o_ack[1]), 64'h2);
            step();
        end
        wb_ack = 1'b0;

        // ---- 4: dwb burst with stb gap, iwb waiting -----------------------
        do_reset();
        set_req(0, 1'b1, 1'b1);
        set_req(1, 1'b1, 1'b1);
        req_we = 2'b10;
        req_adr[31:0] = 32'h0000_0200;
        step();
        for (int b = 0; b < 5; b++) begin
            req_stb[1]       = burst_stb[b];
            wb_ack           = burst_stb[b];
            req_adr[63:32]   = 32'h0000_1000 + 32'(4 * b);
            req_dat[63:32]   = 32'hA5A5_0000 + 32'(b);
            mid();
            for (int d = 0; d < 2; d++)
                check($sformatf("t4_gnt_%0d_%0d", d, b), 64'(o_gnt[d]), 64'h2);
            check($sformatf("t4_cyc_%0d", b), 64'(o_cyc[0]), 64'h1);
            check($sformatf("t4_stb_%0d", b), 64'(o_stb[0]), 64'(burst_stb[b]));
            check($sformatf("t4_ack_%0d", b), 64'(o_ack[0]),
                  burst_stb[b] ? 64'h2 : 64'h0);
            if (burst_stb[b]) begin
                check($sformatf("t4_we_%0d", b),  64'(o_we[0]),  64'h1);
                check($sformatf("t4_adr_%0d", b), 64'(o_adr[0]), 64'h1000 + 64'(4 * b));
                check($sformatf("t4_dat_%0d", b), 64'(o_dat[0]), 64'hA5A5_0000 + 64'(b));
            end
            step();
        end
        wb_ack = 1'b0;
        set_req(1, 1'b0, 1'b0);
        req_we = 2'b00;
        mid();
        check("t4_gnt_fall", 64'(o_gnt[0]), 64'h2);
        check("t4_cyc_fall", 64'(o_cyc[0]), 64'h0);
        step();
        mid();
        check("t4_idle", 64'(o_gnt[0]), 64'h0);
        step();
        mid();
        check("t4_gnt_iwb", 64'(o_gnt[0]), 64'h1);
        check("t4_adr_iwb", 64'(o_adr[0]), 64'h200);

        // ---- 5: watchdog fires after 16 stalled BUSY cycles ----------------
        do_reset();
        set_req(1, 1'b1, 1'b1);
        step();
        for (int i = 1; i <= 16; i++) begin
            mid();
            if (i == 1 || i == 16) begin
                check($sformatf("t5_cyc_%0d", i), 64'(o_cyc[0]), 64'h1);
                check($sformatf("t5_to_%0d", i),  64'(o_to[0]),  64'h0);
                check($sformatf("t5_err_%0d", i), 64'(o_err[0]), 64'h0);
            end
            step();
        end
        mid();
        check("t5_terr_cyc",  64'(o_cyc[0]), 64'h0);
        check("t5_terr_stb",  64'(o_stb[0]), 64'h0);
        check("t5_terr_err",  64'(o_err[0]), 64'h2);
        check("t5_terr_ack",  64'(o_ack[0]), 64'h0);
        check("t5_terr_to",   64'(o_to[0]),  64'h1);
        check("t5_terr_gnt",  64'(o_gnt[0]), 64'h2);
        check("t5_nowd_cyc",  64'(o_cyc[2]), 64'h1);
        check("t5_nowd_to",   64'(o_to[2]),  64'h0);
        step();
        set_req(1, 1'b0, 1'b0);
        mid();
        check("t5_post_to",  64'(o_to[0]),  64'h0);
        check("t5_post_err", 64'(o_err[0]), 64'h0);
        check("t5_post_gnt", 64'(o_gnt[0]), 64'h0);
        step();
        step();
        step();
        wb_ack = 1'b1;
        mid();
        check("t5_late_ack", 64'(o_ack[0]), 64'h0);
        check("t5_late_err", 64'(o_err[0]), 64'h0);
        step();
        wb_ack = 1'b0;

        // ---- 5b: response on the threshold cycle beats the watchdog -------
        do_reset();
        set_req(1, 1'b1, 1'b1);
        step();
        for (int i = 1; i < 16; i++) step();
        wb_ack = 1'b1;
        mid();
        check("t5b_ack", 64'(o_ack[0]), 64'h2);
        step();
        wb_ack = 1'b0;
        mid();
        check("t5b_cyc", 64'(o_cyc[0]), 64'h1);
        check("t5b_to",  64'(o_to[0]),  64'h0);
        check("t5b_err", 64'(o_err[0]), 64'h0);
        step();
        set_req(1, 1'b0, 1'b0);
        step();

        // ---- 6: reset mid-cycle drops the tenure and the late ack ---------
        do_reset();
        set_req(0, 1'b1, 1'b1);
        step();
        step();
        rst = 1'b1;
        mid();
        check("t6_gnt_before", 64'(o_gnt[0]), 64'h1);
        step();
        rst = 1'b0;
        wb_ack = 1'b1;
        mid();
        check("t6_gnt", 64'(o_gnt[0]), 64'h0);
        check("t6_cyc", 64'(o_cyc[0]), 64'h0);
        check("t6_ack", 64'(o_ack[0]), 64'h0);
        step();
        wb_ack = 1'b0;
        mid();
        check("t6_regrant", 64'(o_gnt[0]), 64'h1);
        set_req(0, 1'b0, 1'b0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL sim_timeout: got no end of test, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
